sorted_candidate_serializer: RTL and testbench

//  Downstream consumer of the modulation-select mux in the sorter path. Captures the

---
 rtl/sorted_candidate_serializer.sv | 124 ++++++++++++
 tb/tb_sorted_candidate_serializer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/sorted_candidate_serializer.sv
// Captures a sorted candidate vector on start and streams it out one element per
// valid/ready transfer, best candidate first. Optional ordering monitor: SER_ORDER_CHECK_EN.
module sorted_candidate_serializer #(
  parameter int WIDTH      = 8,
  parameter int NUM_INPUTS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [1:0]                    M,
  input  logic [NUM_INPUTS*WIDTH-1:0]   y,
  output logic                          busy,
  output logic [WIDTH-1:0]              dout,
  output logic [$clog2(NUM_INPUTS)-1:0] dout_idx,
  output logic                          dout_valid,
  input  logic                          dout_ready,
  output logic                          done,
  output logic                          order_err
);

  localparam int IDX_W = $clog2(NUM_INPUTS);
  localparam logic [IDX_W-1:0] LAST_FULL = IDX_W'(NUM_INPUTS - 1);
  localparam logic [IDX_W-1:0] LAST_HALF = IDX_W'(NUM_INPUTS / 2 - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                        state_q, state_d;
  logic [NUM_INPUTS*WIDTH-1:0]   shadow_q, shadow_d;
  logic                          qpsk_q, qpsk_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic                          done_q, done_d;
  logic                          xfer;
  logic                          last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      qpsk_q   <= 1'b0;
      idx_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      qpsk_q   <= qpsk_d;
      idx_q    <= idx_d;
      done_q   <= done_d;
    end
  end

  // dout is a pure select of the shadow, so it keeps the last element once idle
  always_comb begin
    dout = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (idx_q == IDX_W'(i)) dout = shadow_q[i*WIDTH +: WIDTH];
    end
  end

  assign dout_valid = (state_q == SEND);
  assign busy       = (state_q == SEND);
  assign dout_idx   = idx_q;
  assign done       = done_q;
  assign xfer       = dout_valid && dout_ready;
  assign last       = (idx_q == (qpsk_q ? LAST_HALF : LAST_FULL));

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    qpsk_d   = qpsk_q;
    idx_d    = idx_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          shadow_d = y;
          qpsk_d   = (M == 2'b00);
          idx_d    = '0;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (dout_ready) begin
          if (last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef SER_ORDER_CHECK_EN
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             order_err_q, order_err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q      <= '0;
      order_err_q <= 1'b0;
    end else begin
      prev_q      <= prev_d;
      order_err_q <= order_err_d;
    end
  end

  // The first element of a frame has no predecessor to compare against
  always_comb begin
    prev_d      = prev_q;
    order_err_d = order_err_q;
    if (xfer) begin
      prev_d = dout;
      if ((idx_q != '0) && (dout < prev_q)) order_err_d = 1'b1;
    end
  end

  assign order_err = order_err_q;
`else
  assign order_err = 1'b0;
`endif

endmodule

// File: tb/tb_sorted_candidate_serializer.sv
// Self-checking bench for sorted_candidate_serializer: vector table, hand sequences
// and randomized frames checked against an element-list reference model.
module tb_sorted_candidate_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  M;
  logic [31:0] y;
  logic        busy;
  logic [7:0]  dout;
  logic [1:0]  dout_idx;
  logic        dout_valid;
  logic        dout_ready;
  logic        done;
  logic        order_err;

  int n_pass  = 0;
  int n_total = 0;
  logic exp_oe = 1'b0;

  sorted_candidate_serializer #(.WIDTH(8), .NUM_INPUTS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .M(M), .y(y), .busy(busy),
    .dout(dout), .dout_idx(dout_idx), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .done(done), .order_err(order_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] y;
    logic [1:0]  m;
    logic [31:0] exp_el;
    int          n;
    logic [7:0]  stall_mask;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else n_pass++;
  endtask

  // Reference: a frame is the first n elements of the captured vector, in index order
  function automatic int frame_len(input logic [1:0] m);
    return (m == 2'b00) ? 2 : 4;
  endfunction

  task automatic load(input logic [31:0] yv, input logic [1:0] mv);
    chk("idle_valid", dout_valid, 0);
    start = 1'b1; y = yv; M = mv;
    @(negedge clk);
    start = 1'b0; y = $urandom; M = 2'($urandom);
  endtask

  // Called at the negedge after the load edge; returns at the done-cycle negedge
  task automatic stream(input logic [31:0] ex, input int n, input int rmode,
                        input logic [7:0] mask, input bit start_mid, input logic [31:0] y_alt);
    int k = 0;
    int c = 0;
    logic r;
    logic [7:0] e [4];
    for (int i = 0; i < 4; i++) e[i] = ex[i*8 +: 8];
    while (k < n && c < 200) begin
      chk("valid", dout_valid, 1);
      chk("busy", busy, 1);
      chk("dout", dout, e[k]);
      chk("dout_idx", dout_idx, k);
      chk("done_low", done, 0);
      chk("order_err", order_err, exp_oe);
      if (rmode == 0) r = (c < 8) ? !mask[c] : 1'b1;
      else r = ($urandom_range(0, 3) != 0);
      dout_ready = r;
      if (start_mid && c == 0) begin
        start = 1'b1; y = y_alt; M = 2'b00;
      end else begin
        start = 1'b0; y = $urandom; M = 2'($urandom);
      end
`ifdef SER_ORDER_CHECK_EN
      if (r && k > 0 && e[k] < e[k-1]) exp_oe = 1'b1;
`endif
      @(negedge clk);
      if (r) k++;
      c++;
    end
    start = 1'b0;
    chk("frame_in_budget", (c < 200), 1);
    chk("done_pulse", done, 1);
    chk("valid_at_done", dout_valid, 0);
    chk("busy_at_done", busy, 0);
    chk("dout_retained", dout, e[n-1]);
    chk("order_err_done", order_err, exp_oe);
    dout_ready = 1'b0;
  endtask

  vec_t vecs [6];

  initial begin
    vecs[0] = '{y: {8'd40, 8'd30, 8'd20, 8'd10}, m: 2'b00, exp_el: {8'd40, 8'd30, 8'd20, 8'd10}, n: 2, stall_mask: 8'h00};
    vecs[1] = '{y: {8'd40, 8'd30, 8'd20, 8'd10}, m: 2'b01, exp_el: {8'd40, 8'd30, 8'd20, 8'd10}, n: 4, stall_mask: 8'h06};
    vecs[2] = '{y: {8'd40, 8'd30, 8'd20, 8'd10}, m: 2'b11, exp_el: {8'd40, 8'd30, 8'd20, 8'd10}, n: 4, stall_mask: 8'h00};
    vecs[3] = '{y: {8'd255, 8'd128, 8'd2, 8'd1}, m: 2'b10, exp_el: {8'd255, 8'd128, 8'd2, 8'd1}, n: 4, stall_mask: 8'h01};
    vecs[4] = '{y: {8'd0, 8'd0, 8'd200, 8'd3}, m: 2'b00, exp_el: {8'd0, 8'd0, 8'd200, 8'd3}, n: 2, stall_mask: 8'h03};
    vecs[5] = '{y: {8'd5, 8'd9, 8'd7, 8'd1}, m: 2'b01, exp_el: {8'd5, 8'd9, 8'd7, 8'd1}, n: 4, stall_mask: 8'h00};

    rst = 1'b1; start = 1'b0; M = 2'b00; y = '0; dout_ready = 1'b0;
    #12;
    chk("rst_valid", dout_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dout", dout, 0);
    chk("rst_idx", dout_idx, 0);
    chk("rst_order_err", order_err, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      load(vecs[v].y, vecs[v].m);
      stream(vecs[v].exp_el, vecs[v].n, 0, vecs[v].stall_mask, 1'b0, 32'h0);
      @(negedge clk);
      chk("done_one_cycle", done, 0);
    end

    // start during SEND ignored; start in the done cycle begins the next frame
    load({8'd40, 8'd30, 8'd20, 8'd10}, 2'b01);
    stream({8'd40, 8'd30, 8'd20, 8'd10}, 4, 0, 8'h00, 1'b1, {8'd99, 8'd88, 8'd77, 8'd66});
    start = 1'b1; y = {8'd99, 8'd88, 8'd77, 8'd66}; M = 2'b00;
    @(negedge clk);
    start = 1'b0; y = '0;
    stream({8'd99, 8'd88, 8'd77, 8'd66}, 2, 0, 8'h00, 1'b0, 32'h0);

    for (int t = 0; t < 40; t++) begin
      logic [31:0] ry;
      logic [1:0]  rm;
      ry = $urandom;
      rm = 2'($urandom);
      load(ry, rm);
      stream(ry, frame_len(rm), 1, 8'h00, 1'b0, 32'h0);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
        chk("idle_gap_done", done, 0);
      end
    end

    // Asynchronous reset in the middle of a frame aborts it without a done pulse
    load({8'd40, 8'd30, 8'd20, 8'd10}, 2'b01);
    dout_ready = 1'b1;
    @(negedge clk);
    dout_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    exp_oe = 1'b0;
    chk("mid_rst_valid", dout_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_dout", dout, 0);
    chk("mid_rst_idx", dout_idx, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_order_err", order_err, 0);
    @(negedge clk);
    rst = 1'b0;
    dout_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("post_rst_done", done, 0);
      chk("post_rst_valid", dout_valid, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
